// File: rtl/ddr2_dq_tap_calib.sv
// Read-capture calibration sequencer for one DQS group: walks each DQ bit's IDELAY
// tap chain against a rise=1/fall=0 training pattern, centres it and fixes bit-time flips.
module ddr2_dq_tap_calib #(
    parameter int DQ_WIDTH   = 8,
    parameter int TAP_W      = 6,
    parameter int MAX_TAPS   = 63,
    parameter int SETTLE_CYC = 7
) (
    input  logic                clk,
    input  logic                reset0,
    input  logic                calib_start,
    input  logic [DQ_WIDTH-1:0] rd_data_rise,
    input  logic [DQ_WIDTH-1:0] rd_data_fall,
    output logic                data_dlyrst,
    output logic [DQ_WIDTH-1:0] data_dlyce,
    output logic [DQ_WIDTH-1:0] data_dlyinc,
    output logic [DQ_WIDTH-1:0] delay_enable,
    output logic                calib_busy,
    output logic                calib_done,
    output logic                calib_err
);

    localparam int BIT_W = (DQ_WIDTH > 1) ? $clog2(DQ_WIDTH) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(MAX_TAPS);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DQ_WIDTH - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_TAPS,
        S_SETTLE,
        S_SAMPLE,
        S_INC,
        S_CENTER,
        S_NEXT_BIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state, state_d;
    logic [BIT_W-1:0]   bit_idx, bit_d;
    logic [TAP_W-1:0]   tap, tap_d;
    logic [TAP_W-1:0]   first_tap, first_d;
    logic [TAP_W-1:0]   centre, centre_d;
    logic               found, found_d;
    logic [CNT_W-1:0]   settle_cnt, cnt_d;

    logic                dlyrst_d;
    logic [DQ_WIDTH-1:0] dlyce_d;
    logic [DQ_WIDTH-1:0] dlyinc_d;
    logic [DQ_WIDTH-1:0] de_d;
    logic                busy_d;
    logic                done_d;
    logic                err_d;

    logic               rise_b;
    logic               fall_b;
    logic               valid;
    logic               flipped;
    logic [TAP_W-1:0]   last_v;
    logic [TAP_W:0]     pair_sum;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d  = state;
        bit_d    = bit_idx;
        tap_d    = tap;
        first_d  = first_tap;
        centre_d = centre;
        found_d  = found;
        cnt_d    = '0;
        dlyrst_d = 1'b0;
        dlyce_d  = '0;
        dlyinc_d = '0;
        de_d     = delay_enable;
        busy_d   = calib_busy;
        done_d   = calib_done;
        err_d    = calib_err;

        rise_b   = rd_data_rise[bit_idx];
        fall_b   = rd_data_fall[bit_idx];
        valid    = rise_b & ~fall_b;
        flipped  = ~rise_b & fall_b;
        last_v   = tap;
        pair_sum = '0;

        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (calib_start) begin
                    state_d  = S_RST_TAPS;
                    dlyrst_d = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    de_d     = '0;
                end
            end

            S_RST_TAPS: begin
                bit_d   = '0;
                tap_d   = '0;
                found_d = 1'b0;
                state_d = S_SETTLE;
            end

            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = settle_cnt + 1'b1;
                end
            end

            S_SAMPLE: begin
                if (flipped && !delay_enable[bit_idx] && !found) begin
                    // Realign by one bit time and re-examine the same tap.
                    de_d[bit_idx] = 1'b1;
                    state_d       = S_SETTLE;
                end else begin
                    if (valid && !found) begin
                        first_d = tap;
                        found_d = 1'b1;
                    end
                    if (!valid && found) begin
                        last_v  = tap - 1'b1;
                        state_d = S_CENTER;
                    end else if (tap == TAP_MAX) begin
                        last_v  = TAP_MAX;
                        state_d = found_d ? S_CENTER : S_ERR;
                    end else begin
                        dlyce_d[bit_idx]  = 1'b1;
                        dlyinc_d[bit_idx] = 1'b1;
                        state_d           = S_INC;
                    end
                    pair_sum = {1'b0, first_d} + {1'b0, last_v};
                    if (state_d == S_CENTER) begin
                        centre_d = pair_sum[TAP_W:1];
                    end
                    if (state_d == S_ERR) begin
                        err_d  = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            end

            S_INC: begin
                tap_d   = tap + 1'b1;
                state_d = S_SETTLE;
            end

            S_CENTER: begin
                // One decrement pulse per cycle; tap tracks the IDELAY position.
                if (tap != centre) begin
                    dlyce_d[bit_idx] = 1'b1;
                    tap_d            = tap - 1'b1;
                end else begin
                    state_d = S_NEXT_BIT;
                end
            end

            S_NEXT_BIT: begin
                if (bit_idx == BIT_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    bit_d   = bit_idx + 1'b1;
                    tap_d   = '0;
                    found_d = 1'b0;
                    state_d = S_SETTLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset0) begin
            state        <= S_IDLE;
            bit_idx      <= '0;
            tap          <= '0;
            first_tap    <= '0;
            centre       <= '0;
            found        <= 1'b0;
            settle_cnt   <= '0;
            data_dlyrst  <= 1'b0;
            data_dlyce   <= '0;
            data_dlyinc  <= '0;
            delay_enable <= '0;
            calib_busy   <= 1'b0;
            calib_done   <= 1'b0;
            calib_err    <= 1'b0;
        end else begin
            state        <= state_d;
            bit_idx      <= bit_d;
            tap          <= tap_d;
            first_tap    <= first_d;
            centre       <= centre_d;
            found        <= found_d;
            settle_cnt   <= cnt_d;
            data_dlyrst  <= dlyrst_d;
            data_dlyce   <= dlyce_d;
            data_dlyinc  <= dlyinc_d;
            delay_enable <= de_d;
            calib_busy   <= busy_d;
            calib_done   <= done_d;
            calib_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_ddr2_dq_tap_calib.sv
// Bench for ddr2_dq_tap_calib: an IDELAY/IOB model answers the DUT's tap moves, and a
// table of calibration scenarios is queued as expectations and compared on completion.
module tb_ddr2_dq_tap_calib;

    localparam int NB     = 8;
    localparam int BUDGET = 30000;

    logic          clk = 1'b0;
    logic          reset0;
    logic          calib_start;
    logic [NB-1:0] rd_data_rise = '0;
    logic [NB-1:0] rd_data_fall = '0;
    logic          data_dlyrst;
    logic [NB-1:0] data_dlyce;
    logic [NB-1:0] data_dlyinc;
    logic [NB-1:0] delay_enable;
    logic          calib_busy;
    logic          calib_done;
    logic          calib_err;

    ddr2_dq_tap_calib dut (
        .clk          (clk),
        .reset0       (reset0),
        .calib_start  (calib_start),
        .rd_data_rise (rd_data_rise),
        .rd_data_fall (rd_data_fall),
        .data_dlyrst  (data_dlyrst),
        .data_dlyce   (data_dlyce),
        .data_dlyinc  (data_dlyinc),
        .delay_enable (delay_enable),
        .calib_busy   (calib_busy),
        .calib_done   (calib_done),
        .calib_err    (calib_err)
    );

    always #5 clk = ~clk;

    // Per-bit window [lo..hi] (lo > hi = never valid), flip-until-realigned flag, and results.
    typedef struct packed {
        logic [NB-1:0][7:0] lo;
        logic [NB-1:0][7:0] hi;
        logic [NB-1:0]      flip;
        logic [NB-1:0][7:0] n_inc;
        logic [NB-1:0][7:0] n_dec;
        logic [NB-1:0][7:0] fin_tap;
        logic [NB-1:0]      de;
        logic               done;
        logic               err;
    } vec_t;

    vec_t vecs [4];
    vec_t cur;
    vec_t sb_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    int tap_m   [NB];
    int inc_cnt [NB];
    int dec_cnt [NB];
    bit dec_seen[NB];
    int rst_cnt   = 0;
    int pulse_cnt = 0;
    int proto_err = 0;

    initial begin
        cur = '0;
        for (int b = 0; b < NB; b++) begin
            tap_m[b] = 0; inc_cnt[b] = 0; dec_cnt[b] = 0; dec_seen[b] = 1'b0;
        end
    end

    // IOB model: applies the registered tap commands seen in each cycle, then presents read data.
    always @(negedge clk) begin
        if (data_dlyrst) begin
            rst_cnt++;
            for (int b = 0; b < NB; b++) begin
                tap_m[b] = 0; dec_seen[b] = 1'b0;
            end
        end
        if ($countones(data_dlyce) > 1) proto_err++;
        if (data_dlyce == '0 && data_dlyinc != '0) proto_err++;
        for (int b = 0; b < NB; b++) begin
            if (data_dlyce[b]) begin
                pulse_cnt++;
                if (data_dlyinc[b]) begin
                    tap_m[b]++; inc_cnt[b]++;
                    if (dec_seen[b]) proto_err++;
                end else begin
                    tap_m[b]--; dec_cnt[b]++; dec_seen[b] = 1'b1;
                end
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (cur.flip[b] && !delay_enable[b]) begin
                rd_data_rise[b] = 1'b0; rd_data_fall[b] = 1'b1;
            end else if (tap_m[b] >= int'(cur.lo[b]) && tap_m[b] <= int'(cur.hi[b])) begin
                rd_data_rise[b] = 1'b1; rd_data_fall[b] = 1'b0;
            end else begin
                rd_data_rise[b] = 1'b0; rd_data_fall[b] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic vec_t base_vec();
        vec_t v;
        v = '0;
        for (int b = 0; b < NB; b++) begin
            v.lo[b] = 8'd0; v.hi[b] = 8'd0;
            v.n_inc[b] = 8'd1; v.n_dec[b] = 8'd1; v.fin_tap[b] = 8'd0;
        end
        v.done = 1'b1;
        return v;
    endfunction

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            tick();
            if (calib_done || calib_err) ok = 1'b1;
        end
    endtask

    task automatic run_vec(input int idx, input bit mid_pulse);
        int  base_inc [NB];
        int  base_dec [NB];
        int  base_rst;
        int  base_proto;
        bit  ok;
        vec_t e;
        cur = vecs[idx];
        sb_q.push_back(vecs[idx]);
        for (int b = 0; b < NB; b++) begin
            base_inc[b] = inc_cnt[b]; base_dec[b] = dec_cnt[b];
        end
        base_rst   = rst_cnt;
        base_proto = proto_err;

        calib_start = 1'b1;
        tick();
        calib_start = 1'b0;
        check($sformatf("v%0d start dlyrst", idx), int'(data_dlyrst), 1);
        check($sformatf("v%0d start busy", idx), int'(calib_busy), 1);
        check($sformatf("v%0d start done/err/de", idx),
              int'({calib_done, calib_err, delay_enable}), 0);
        tick();
        check($sformatf("v%0d dlyrst width", idx), int'(data_dlyrst), 0);

        if (mid_pulse) begin
            repeat (200) tick();
            calib_start = 1'b1;
            tick();
            calib_start = 1'b0;
            check($sformatf("v%0d mid start busy", idx), int'(calib_busy), 1);
            check($sformatf("v%0d mid start dlyrst", idx), int'(data_dlyrst), 0);
        end

        wait_end(ok);
        check($sformatf("v%0d finished", idx), int'(ok), 1);
        repeat (10) tick();

        e = sb_q.pop_front();
        check($sformatf("v%0d done", idx), int'(calib_done), int'(e.done));
        check($sformatf("v%0d err", idx), int'(calib_err), int'(e.err));
        check($sformatf("v%0d busy", idx), int'(calib_busy), 0);
        check($sformatf("v%0d delay_enable", idx), int'(delay_enable), int'(e.de));
        check($sformatf("v%0d dlyrst count", idx), rst_cnt - base_rst, 1);
        check($sformatf("v%0d pulse protocol", idx), proto_err - base_proto, 0);
        for (int b = 0; b < NB; b++) begin
            check($sformatf("v%0d b%0d inc", idx, b), inc_cnt[b] - base_inc[b], int'(e.n_inc[b]));
            check($sformatf("v%0d b%0d dec", idx, b), dec_cnt[b] - base_dec[b], int'(e.n_dec[b]));
            check($sformatf("v%0d b%0d tap", idx, b), tap_m[b], int'(e.fin_tap[b]));
        end
    endtask

    initial begin
        bit ok;
        int p0;

        vecs[0] = base_vec();
        vecs[0].lo[0] = 8'd10; vecs[0].hi[0] = 8'd30;
        vecs[0].n_inc[0] = 8'd31; vecs[0].n_dec[0] = 8'd11; vecs[0].fin_tap[0] = 8'd20;

        vecs[1] = base_vec();
        vecs[1].flip[1] = 1'b1; vecs[1].lo[1] = 8'd0; vecs[1].hi[1] = 8'd5;
        vecs[1].n_inc[1] = 8'd6; vecs[1].n_dec[1] = 8'd4; vecs[1].fin_tap[1] = 8'd2;
        vecs[1].de = 8'h02;

        vecs[2] = base_vec();
        vecs[2].lo[3] = 8'd255; vecs[2].hi[3] = 8'd0;
        vecs[2].n_inc[3] = 8'd63; vecs[2].n_dec[3] = 8'd0; vecs[2].fin_tap[3] = 8'd63;
        for (int b = 4; b < NB; b++) begin
            vecs[2].n_inc[b] = 8'd0; vecs[2].n_dec[b] = 8'd0; vecs[2].fin_tap[b] = 8'd0;
        end
        vecs[2].done = 1'b0; vecs[2].err = 1'b1;

        vecs[3] = base_vec();
        vecs[3].lo[2] = 8'd40; vecs[3].hi[2] = 8'd63;
        vecs[3].n_inc[2] = 8'd63; vecs[3].n_dec[2] = 8'd12; vecs[3].fin_tap[2] = 8'd51;

        reset0 = 1'b1;
        calib_start = 1'b0;
        repeat (3) tick();
        reset0 = 1'b0;
        tick();
        check("reset outputs", int'({data_dlyrst, data_dlyce, data_dlyinc, delay_enable,
                                      calib_busy, calib_done, calib_err}), 0);

        for (int i = 0; i < 4; i++) run_vec(i, 1'b0);

        // Recalibrate from DONE with a stray calib_start mid-walk.
        run_vec(0, 1'b1);

        // Reset in the middle of bit0's centring decrements.
        cur = vecs[0];
        calib_start = 1'b1;
        tick();
        calib_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            tick();
            if (data_dlyce[0] && !data_dlyinc[0]) ok = 1'b1;
        end
        check("reset scen: dec pulse seen", int'(ok), 1);
        reset0 = 1'b1;
        tick();
        reset0 = 1'b0;
        check("reset scen: outputs cleared", int'({data_dlyrst, data_dlyce, data_dlyinc, delay_enable,
                                                   calib_busy, calib_done, calib_err}), 0);
        p0 = pulse_cnt;
        repeat (50) tick();
        check("reset scen: no pulses after reset", pulse_cnt - p0, 0);
        check("reset scen: still idle", int'(calib_busy), 0);
        calib_start = 1'b1;
        tick();
        calib_start = 1'b0;
        check("reset scen: dlyrst after start", int'(data_dlyrst), 1);
        tick();
        check("reset scen: dlyrst one cycle", int'(data_dlyrst), 0);
        wait_end(ok);
        check("reset scen: finished", int'(ok), 1);
        check("reset scen: done", int'({calib_done, calib_err}), 2);
        check("reset scen: bit0 tap", tap_m[0], 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
